// File: rtl/serial_host.sv
// serial_host: initiator that loads B, shifts A out and collects serial C with timeout
module serial_host #(
  parameter int A_WIDTH = 4,
  parameter int B_WIDTH = 4,
  parameter int C_WIDTH = 3,
  parameter int GAP = 1,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [A_WIDTH-1:0] req_a,
  input  logic [B_WIDTH-1:0] req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [C_WIDTH-1:0] resp_c,
  output logic               resp_timeout,
  output logic               load_b,
  output logic [B_WIDTH-1:0] b_out,
  output logic               start_a,
  output logic               a_bit,
  input  logic               start_c,
  input  logic               c_bit
);
  typedef enum logic [2:0] {IDLE, LOAD_B, GAP_W, SEND_A, WAIT_C, RECV_C, DONE} state_t;
  localparam int M1 = A_WIDTH > C_WIDTH ? A_WIDTH : C_WIDTH;
  localparam int M2 = TIMEOUT > GAP ? TIMEOUT : GAP;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
  state_t state, nstate;
  logic [CW-1:0] cnt, cnt_d;
  logic [A_WIDTH-1:0] a_sh, a_sh_d;
  logic [C_WIDTH-1:0] c_sh, c_nx, resp_c_d;
  logic [B_WIDTH-1:0] b_out_d;
  logic tmo, cap, req_ready_d, resp_valid_d, resp_timeout_d, load_b_d, start_a_d, a_bit_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      a_sh <= '0;
      c_sh <= '0;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_timeout <= 1'b0;
      resp_c <= '0;
      load_b <= 1'b0;
      b_out <= '0;
      start_a <= 1'b0;
      a_bit <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= cnt_d;
      a_sh <= a_sh_d;
      c_sh <= c_nx;
      req_ready <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_timeout <= resp_timeout_d;
      resp_c <= resp_c_d;
      load_b <= load_b_d;
      b_out <= b_out_d;
      start_a <= start_a_d;
      a_bit <= a_bit_d;
    end
  end
  always_comb begin
    nstate = state;
    tmo = 1'b0;
    case (state)
      IDLE:    if (req_valid) nstate = LOAD_B;
      LOAD_B:  nstate = GAP > 0 ? GAP_W : SEND_A;
      GAP_W:   if (cnt == CW'(GAP - 1)) nstate = SEND_A;
      SEND_A:  if (cnt == CW'(A_WIDTH - 1)) nstate = WAIT_C;
      WAIT_C: begin
        if (start_c) nstate = C_WIDTH == 1 ? DONE : RECV_C;
        else if (cnt == CW'(TIMEOUT - 1)) begin
          nstate = DONE;
          tmo = 1'b1;
        end
      end
      RECV_C:  if (cnt == CW'(C_WIDTH - 2)) nstate = DONE;
      DONE:    if (resp_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  // Output registers are loaded from the upcoming state so every strobe lines up with its state
  always_comb begin
    cap = (state == WAIT_C && start_c) || state == RECV_C;
    c_nx = cap ? (c_sh >> 1) | (C_WIDTH'(c_bit) << (C_WIDTH - 1)) : c_sh;
    cnt_d = nstate != state ? '0 : cnt + 1'b1;
    a_sh_d = state == IDLE && req_valid ? req_a : nstate == SEND_A ? a_sh >> 1 : a_sh;
    b_out_d = state == IDLE && req_valid ? req_b : b_out;
    req_ready_d = nstate == IDLE;
    load_b_d = nstate == LOAD_B;
    start_a_d = nstate == SEND_A && state != SEND_A;
    a_bit_d = nstate == SEND_A ? a_sh[0] : 1'b0;
    resp_valid_d = nstate == DONE;
    resp_timeout_d = nstate == DONE && (state == DONE ? resp_timeout : tmo);
    resp_c_d = nstate == DONE && state != DONE ? (tmo ? '0 : c_nx) : resp_c;
  end
endmodule

// File: tb/tb_serial_host.sv
// tb_serial_host: scoreboard bench for serial_host (default build plus GAP=0, C_WIDTH=1 build)
module tb_serial_host;
  localparam int G = 1;
  localparam int A = 4;
  logic clk = 0, reset;
  logic req_valid, req_ready, resp_valid, resp_ready, resp_timeout, load_b, start_a, a_bit, start_c, c_bit;
  logic [3:0] req_a, req_b, b_out;
  logic [2:0] resp_c;
  logic u1_req_valid, u1_req_ready, u1_resp_valid, u1_resp_ready, u1_resp_timeout;
  logic u1_load_b, u1_start_a, u1_a_bit, u1_start_c, u1_c_bit;
  logic [3:0] u1_req_a, u1_req_b, u1_b_out;
  logic [0:0] u1_resp_c;
  int checks = 0, failures = 0;
  logic [3:0] sb[$];
  always #5 clk = ~clk;
  serial_host dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_c(resp_c), .resp_timeout(resp_timeout),
    .load_b(load_b), .b_out(b_out), .start_a(start_a), .a_bit(a_bit), .start_c(start_c), .c_bit(c_bit)
  );
  serial_host #(.GAP(0), .C_WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(u1_req_valid), .req_ready(u1_req_ready), .req_a(u1_req_a),
    .req_b(u1_req_b), .resp_valid(u1_resp_valid), .resp_ready(u1_resp_ready), .resp_c(u1_resp_c),
    .resp_timeout(u1_resp_timeout), .load_b(u1_load_b), .b_out(u1_b_out), .start_a(u1_start_a),
    .a_bit(u1_a_bit), .start_c(u1_start_c), .c_bit(u1_c_bit)
  );
  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    checks++;
    if ({req_ready, resp_valid, resp_timeout, load_b, start_a, a_bit, b_out, resp_c} !== {1'b1, 5'b0, 4'h0, 3'h0}) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", {req_ready, resp_valid, resp_timeout, load_b, start_a, a_bit, b_out, resp_c}, {1'b1, 12'b0});
    end
  endtask
  task automatic do_txn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c, input int d,
                        input bit noc, input bit spur, input int bp, input string nm);
    logic [3:0] exp, hold;
    logic ea;
    int lat;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL %s_req_ready got=%b want=1", nm, req_ready); end
    req_valid = 1; req_a = a; req_b = b;
    @(posedge clk);
    for (int t = 1; t <= 1 + G + A; t++) begin
      @(negedge clk);
      req_valid = 0;
      start_c = spur && (t == 1 || t == 3);
      c_bit = spur;
      ea = 1'b0;
      if (t >= 2 + G) ea = a[t-2-G];
      checks++;
      if ({load_b, start_a, a_bit} !== {t == 1, t == 2 + G, ea}) begin
        failures++;
        $display("FAIL %s_strobes cycle=%0d got=%b want=%b", nm, t, {load_b, start_a, a_bit}, {t == 1, t == 2 + G, ea});
      end
      if (t == 1) begin
        checks++;
        if (b_out !== b) begin failures++; $display("FAIL %s_b_out got=%h want=%h", nm, b_out, b); end
      end
    end
    sb.push_back(noc ? 4'b1000 : {1'b0, c});
    lat = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
      start_c = !noc && lat == d;
      c_bit = (!noc && lat >= d && lat < d + 3) ? c[lat-d] : 1'b0;
    end
    start_c = 0; c_bit = 0;
    checks++;
    if (lat !== (noc ? 17 : d + 3)) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=%0d", nm, lat, noc ? 17 : d + 3);
    end
    exp = sb.pop_front();
    hold = {resp_timeout, resp_c};
    checks++;
    if ({resp_valid, resp_timeout, resp_c} !== {1'b1, exp}) begin
      failures++;
      $display("FAIL %s_resp got=%b want=%b", nm, {resp_valid, resp_timeout, resp_c}, {1'b1, exp});
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready, resp_timeout, resp_c} !== {2'b10, exp}) begin
        failures++;
        $display("FAIL %s_backpressure cycle=%0d got=%b want=%b", nm, i, {resp_valid, req_ready, resp_timeout, resp_c}, {2'b10, exp});
      end
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    checks++;
    if ({resp_valid, resp_timeout, req_ready, resp_c} !== {3'b001, hold[2:0]}) begin
      failures++;
      $display("FAIL %s_after_handshake got=%b want=%b", nm, {resp_valid, resp_timeout, req_ready, resp_c}, {3'b001, hold[2:0]});
    end
  endtask
  task automatic test_reset_mid_send;
    bit seen = 0;
    @(negedge clk);
    req_valid = 1; req_a = 4'b0110; req_b = 4'h9;
    @(posedge clk);
    for (int t = 1; t <= 3 + G; t++) begin
      @(negedge clk);
      req_valid = 0;
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    checks++;
    if ({load_b, start_a, a_bit, resp_valid, req_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_mid_send got=%b want=00001", {load_b, start_a, a_bit, resp_valid, req_ready});
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start_c = i == 3;
      c_bit = i >= 3 && i < 6;
      if (resp_valid || start_a || load_b) seen = 1;
    end
    start_c = 0; c_bit = 0;
    checks++;
    if (seen !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_no_response got=%b%b want=01", seen, req_ready);
    end
  endtask
  task automatic test_gap0_c1(input logic [3:0] a, input logic cb, input int d);
    logic [3:0] exp;
    logic ea;
    int lat;
    @(negedge clk);
    u1_req_valid = 1; u1_req_a = a; u1_req_b = 4'hc;
    @(posedge clk);
    for (int t = 1; t <= 1 + A; t++) begin
      @(negedge clk);
      u1_req_valid = 0;
      ea = 1'b0;
      if (t >= 2) ea = a[t-2];
      checks++;
      if ({u1_load_b, u1_start_a, u1_a_bit} !== {t == 1, t == 2, ea}) begin
        failures++;
        $display("FAIL g0_strobes cycle=%0d got=%b want=%b", t, {u1_load_b, u1_start_a, u1_a_bit}, {t == 1, t == 2, ea});
      end
    end
    sb.push_back({3'b0, cb});
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (u1_resp_valid) break;
      u1_start_c = lat == d;
      u1_c_bit = lat == d ? cb : 1'b0;
    end
    u1_start_c = 0; u1_c_bit = 0;
    exp = sb.pop_front();
    checks++;
    if (lat !== d + 1 || {u1_resp_timeout, u1_resp_c} !== exp[1:0]) begin
      failures++;
      $display("FAIL g0_resp lat=%0d want=%0d got=%b want=%b", lat, d + 1, {u1_resp_timeout, u1_resp_c}, exp[1:0]);
    end
    u1_resp_ready = 1;
    @(negedge clk);
    u1_resp_ready = 0;
    checks++;
    if ({u1_resp_valid, u1_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL g0_handshake got=%b want=01", {u1_resp_valid, u1_req_ready});
    end
  endtask
  initial begin
    {req_valid, resp_ready, start_c, c_bit, req_a, req_b} = '0;
    {u1_req_valid, u1_resp_ready, u1_start_c, u1_c_bit, u1_req_a, u1_req_b} = '0;
    test_reset();
    do_txn(4'b1011, 4'h6, 3'b101, 2, 0, 0, 0, "basic");
    do_txn(4'b0101, 4'h3, 3'b000, 0, 1, 0, 0, "timeout");
    do_txn(4'b1110, 4'ha, 3'b110, 16, 0, 0, 0, "late_start_c");
    do_txn(4'b0011, 4'h5, 3'b010, 1, 0, 0, 5, "backpressure");
    do_txn(4'b1000, 4'hf, 3'b000, 0, 1, 0, 5, "timeout_bp");
    test_reset_mid_send();
    do_txn(4'b1100, 4'h1, 3'b011, 3, 0, 1, 0, "spurious");
    do_txn(4'b0001, 4'h7, 3'b111, 1, 0, 0, 0, "back_to_back");
    test_gap0_c1(4'b1101, 1'b1, 1);
    test_gap0_c1(4'b0110, 1'b0, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_host.md
Name: serial_host

Overview:
- Initiator-side partner of the operand/result serial controller.
- Accepts one parallel request (operands A and B) from the local host and issues a `load_b` pulse with parallel B.
- Transmits A serially, LSB first, framed by `start_a`.
- Receives result C serially, LSB first, framed by `start_c`, then returns C (or a timeout flag) on a valid/ready response port.

Parameters:
- A_WIDTH, 4, serial operand A bit count (≥1).
- B_WIDTH, 4, parallel operand B width.
- C_WIDTH, 3, serial result C bit count (≥1).
- GAP, 1, idle cycles between the `load_b` cycle and the `start_a` cycle (0..15).
- TIMEOUT, 16, max cycles spent waiting for `start_c` (≥1).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  host request valid
- req_ready  out  1  high only in IDLE
- req_a  in  A_WIDTH  operand A
- req_b  in  B_WIDTH  operand B
- resp_valid  out  1  result available
- resp_ready  in  1  host accepts result
- resp_c  out  C_WIDTH  received result (0 on timeout)
- resp_timeout  out  1  no `start_c` within TIMEOUT
- load_b  out  1  one-cycle pulse, B valid on `b_out`
- b_out  out  B_WIDTH  parallel B, held from LOAD_B until next request
- start_a  out  1  one-cycle frame pulse with first A bit
- a_bit  out  1  serial A data
- start_c  in  1  peer frame pulse with first C bit
- c_bit  in  1  serial C data

Behaviour:
- Synchronous active-high reset, and its reset values:
  - state IDLE, counters 0.
  - Outputs: `req_ready`=1 after reset releases; `resp_valid`, `resp_timeout`, `load_b`, `start_a`, `a_bit` = 0; `b_out`, `resp_c` = 0.
- All outputs are registered.
- Reset mid-operation aborts the transaction:
  - No further pulses.
  - Partial C is discarded.
  - No response is produced.
- States and transitions:
  - IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch `req_a`/`req_b` into shift/hold regs → LOAD_B.
  - LOAD_B (1 cycle): `load_b`=1, `b_out`=B. → GAP_W if GAP>0, else SEND_A.
  - GAP_W: GAP cycles with all strobes 0 → SEND_A.
  - SEND_A (A_WIDTH cycles): `a_bit`=A[i] in the i-th cycle, i=0..A_WIDTH-1; `start_a`=1 only when i=0. After the last bit → WAIT_C; `a_bit` returns to 0.
  - WAIT_C:
    - The wait counter counts cycles 1..TIMEOUT.
    - `start_c`=1 in any of those cycles: capture `c_bit` as C[0] → RECV_C (if C_WIDTH=1, → DONE directly).
    - If `start_c` arrives in cycle TIMEOUT, it is accepted; capture wins over timeout.
    - No `start_c` after TIMEOUT cycles → DONE with `resp_timeout`=1, `resp_c`=0.
  - RECV_C: capture `c_bit` into C[1..C_WIDTH-1] on consecutive cycles, no gaps. `start_c` is ignored here. After C[C_WIDTH-1] → DONE.
  - DONE:
    - `resp_valid`=1; `resp_c` and `resp_timeout` are stable while `resp_valid`&&!`resp_ready`.
    - On `resp_ready` → IDLE. `resp_valid` and `resp_timeout` drop the next cycle; `resp_c` holds its value.
- `start_c` in any state other than WAIT_C is ignored and has no side effects.
- Latency, with request accepted at edge k:
  - `load_b` high in cycle k+1.
  - `start_a` high in cycle k+2+GAP.
  - Last A bit in cycle k+1+GAP+A_WIDTH.
  - `resp_valid` high the cycle after the last C bit is sampled.
- Back-to-back: `req_ready` is high the cycle after the response handshake.

Test Plan:
1. Basic transfer (defaults):
   - Stimulus: `req_a`=4'b1011, `req_b`=4'h6 accepted at cycle 0; peer drives `start_c` 2 cycles after the last A bit with C bits 1,0,1.
   - Required: `load_b`=1 and `b_out`=6 at cycle 1; `start_a` at cycle 3; `a_bit` = 1,1,0,1 on cycles 3–6; `resp_c`=3'b101, `resp_timeout`=0.
2. Timeout:
   - Stimulus: no `start_c` ever.
   - Required: after exactly 16 WAIT_C cycles, `resp_valid`=1, `resp_timeout`=1, `resp_c`=0. A `start_c` pulse in wait cycle 16 instead yields a normal response.
3. Backpressure:
   - Stimulus: `resp_ready`=0 for 5 cycles after `resp_valid` rises.
   - Required: `resp_valid`, `resp_c` and `resp_timeout` stay constant; `req_ready`=0 throughout; `req_ready`=1 the cycle after the handshake.
4. Reset mid-SEND_A:
   - Stimulus: assert `reset` during the 2nd A bit.
   - Required: next cycle all strobes 0, `resp_valid`=0; `req_ready`=1 after reset releases; no response ever appears for the aborted request.
5. Spurious `start_c`:
   - Stimulus: pulse `start_c` during LOAD_B and during SEND_A.
   - Required: state unaffected; the later legitimate frame with C=3'b011 returns `resp_c`=3'b011.
6. GAP=0, C_WIDTH=1 build:
   - Required: `start_a` at cycle 2 immediately after `load_b`; a single-bit C frame → `resp_valid` the next cycle with the captured bit.
